serial_adder: RTL and testbench

- Parametrised bit-serial/digit-serial adder; successor to the single-bit full adder (a, b, ci -> sum, co).
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, reusing one DIGIT-bit ripple cell across cycles.
- Valid/ready handshake on input and output, so it drops into streaming datapaths and is bench-driven like the existing adder.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_digit_adder.sv | 29 ++
 rtl/serial_adder.sv | 166 ++++++++++++++++
 tb/tb_serial_adder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the digit-serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Step counter width; a single-step adder still keeps a one-bit counter.
  function automatic int cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// rtl/serial_adder_digit_adder.sv - combinational DIGIT-bit ripple-carry cell
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_top
);

  logic [DIGIT:0] c;

  // Ripple the carry through DIGIT full-adder bits, LSB first.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[DIGIT];
  assign c_top = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder with valid/ready handshakes; SERIAL_ADDER_OVF_EN adds ovf
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [DIGIT-1:0]       dig_s;
  logic                   dig_co;
  logic                   dig_c_top;
  logic [WIDTH+DIGIT-1:0] sum_cat;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .ci    (carry_q),
    .s     (dig_s),
    .co    (dig_co),
    .c_top (dig_c_top)
  );

`ifndef SERIAL_ADDER_OVF_EN
  logic unused_c_top;
  assign unused_c_top = dig_c_top;
`endif

  // Next-state logic: accept in IDLE, one digit per cycle in RUN, wait for the consumer in HOLD.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    co_d        = co_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d       = ovf_q;
`endif
    sum_cat     = {dig_s, sum_q};

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = b;
          carry_d    = ci;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        // New digit enters from the MSB side so the last step leaves the sum aligned.
        sum_d   = sum_cat[WIDTH+DIGIT-1:DIGIT];
        carry_d = dig_co;
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        if (cnt_q == LAST_STEP) begin
          cnt_d       = '0;
          co_d        = dig_co;
          out_valid_d = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d       = dig_co ^ dig_c_top;
`endif
          state_d     = HOLD;
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      co_q        <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      co_q        <= co_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign co        = co_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (8/1 and 8/4 instances)
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       u1_in_valid = 1'b0;
  logic       u1_in_ready;
  logic [7:0] u1_a = '0;
  logic [7:0] u1_b = '0;
  logic       u1_ci = 1'b0;
  logic       u1_out_valid;
  logic       u1_out_ready = 1'b1;
  logic [7:0] u1_sum;
  logic       u1_co;

  logic       u4_in_valid = 1'b0;
  logic       u4_in_ready;
  logic [7:0] u4_a = '0;
  logic [7:0] u4_b = '0;
  logic       u4_ci = 1'b0;
  logic       u4_out_valid;
  logic       u4_out_ready = 1'b1;
  logic [7:0] u4_sum;
  logic       u4_co;

`ifdef SERIAL_ADDER_OVF_EN
  logic       u1_ovf;
  logic       u4_ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (u1_in_valid),
    .in_ready  (u1_in_ready),
    .a         (u1_a),
    .b         (u1_b),
    .ci        (u1_ci),
    .out_valid (u1_out_valid),
    .out_ready (u1_out_ready),
    .sum       (u1_sum),
    .co        (u1_co)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (u1_ovf)
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (u4_in_valid),
    .in_ready  (u4_in_ready),
    .a         (u4_a),
    .b         (u4_b),
    .ci        (u4_ci),
    .out_valid (u4_out_valid),
    .out_ready (u4_out_ready),
    .sum       (u4_sum),
    .co        (u4_co)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (u4_ovf)
`endif
  );

  // Present operands for one accepting edge; returns at the negedge after it.
  task automatic start_u1(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    u1_a = av; u1_b = bv; u1_ci = cv; u1_in_valid = 1'b1;
    @(negedge clk);
    u1_in_valid = 1'b0;
  endtask

  task automatic start_u4(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    u4_a = av; u4_b = bv; u4_ci = cv; u4_in_valid = 1'b1;
    @(negedge clk);
    u4_in_valid = 1'b0;
  endtask

  // Edges from the accepting edge until out_valid is seen (bounded).
  task automatic wait_u1(output int lat);
    lat = 0;
    while (!u1_out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_u4(output int lat);
    lat = 0;
    while (!u4_out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (u1_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", u1_in_ready); end
    total++; if (u1_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", u1_out_valid); end
    total++; if (u1_sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h want=00", u1_sum); end
    total++; if (u1_co !== 1'b0) begin bad++; $display("FAIL reset_co got=%b want=0", u1_co); end
    total++; if (u4_in_ready !== 1'b1) begin bad++; $display("FAIL reset_u4_in_ready got=%b want=1", u4_in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_digit1;
    int lat;
    start_u1(8'hFF, 8'h01, 1'b0);
    total++; if (u1_in_ready !== 1'b0) begin bad++; $display("FAIL d1_in_ready_run got=%b want=0", u1_in_ready); end
    wait_u1(lat);
    total++; if (lat != 8) begin bad++; $display("FAIL d1_latency got=%0d want=8", lat); end
    total++; if (u1_sum !== 8'h00) begin bad++; $display("FAIL d1_sum got=%h want=00", u1_sum); end
    total++; if (u1_co !== 1'b1) begin bad++; $display("FAIL d1_co got=%b want=1", u1_co); end
    @(negedge clk);
    start_u1(8'h80, 8'h80, 1'b1);
    wait_u1(lat);
    total++; if (u1_sum !== 8'h01 || u1_co !== 1'b1) begin bad++; $display("FAIL d1_ci_sum got=%h/%b want=01/1", u1_sum, u1_co); end
    @(negedge clk);
  endtask

  task automatic test_digit4;
    int lat;
    start_u4(8'h3C, 8'h45, 1'b1);
    wait_u4(lat);
    total++; if (lat != 2) begin bad++; $display("FAIL d4_latency got=%0d want=2", lat); end
    total++; if (u4_sum !== 8'h82) begin bad++; $display("FAIL d4_sum got=%h want=82", u4_sum); end
    total++; if (u4_co !== 1'b0) begin bad++; $display("FAIL d4_co got=%b want=0", u4_co); end
    @(negedge clk);
    start_u4(8'hFF, 8'hFF, 1'b1);
    wait_u4(lat);
    total++; if (u4_sum !== 8'hFF || u4_co !== 1'b1) begin bad++; $display("FAIL d4_max got=%h/%b want=ff/1", u4_sum, u4_co); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int lat;
    u1_out_ready = 1'b0;
    start_u1(8'hA5, 8'h3C, 1'b0);
    wait_u1(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (u1_out_valid !== 1'b1 || u1_sum !== 8'hE1 || u1_co !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%b want=1/e1/0", i, u1_out_valid, u1_sum, u1_co);
      end
    end
    u1_out_ready = 1'b1;
    @(negedge clk);
    total++; if (u1_out_valid !== 1'b0) begin bad++; $display("FAIL bp_drop got=%b want=0", u1_out_valid); end
    total++; if (u1_in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready got=%b want=1", u1_in_ready); end
  endtask

  task automatic test_ignore_during_run;
    int lat;
    @(negedge clk);
    u1_a = 8'h12; u1_b = 8'h34; u1_ci = 1'b0; u1_in_valid = 1'b1;
    @(negedge clk);
    u1_a = 8'h55; u1_b = 8'h22;
    wait_u1(lat);
    total++; if (lat != 8 || u1_sum !== 8'h46 || u1_co !== 1'b0) begin
      bad++; $display("FAIL ign_first got=%0d/%h/%b want=8/46/0", lat, u1_sum, u1_co);
    end
    @(negedge clk);
    total++; if (u1_in_ready !== 1'b1) begin bad++; $display("FAIL ign_idle got=%b want=1", u1_in_ready); end
    @(negedge clk);
    u1_in_valid = 1'b0;
    total++; if (u1_in_ready !== 1'b0) begin bad++; $display("FAIL ign_second_accept got=%b want=0", u1_in_ready); end
    wait_u1(lat);
    total++; if (lat != 8 || u1_sum !== 8'h77) begin bad++; $display("FAIL ign_second got=%0d/%h want=8/77", lat, u1_sum); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int seen = 0;
    start_u1(8'hF0, 8'h0F, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (u1_in_ready !== 1'b1 || u1_out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_hs got=%b/%b want=1/0", u1_in_ready, u1_out_valid);
    end
    total++; if (u1_sum !== 8'h00 || u1_co !== 1'b0) begin bad++; $display("FAIL rst_mid_data got=%h/%b want=00/0", u1_sum, u1_co); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (u1_out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_no_output got=%0d want=0", seen); end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf;
    int lat;
    start_u1(8'h7F, 8'h01, 1'b0);
    wait_u1(lat);
    total++; if (u1_sum !== 8'h80 || u1_co !== 1'b0 || u1_ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_set got=%h/%b/%b want=80/0/1", u1_sum, u1_co, u1_ovf);
    end
    @(negedge clk);
    start_u1(8'hFF, 8'h01, 1'b0);
    wait_u1(lat);
    total++; if (u1_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", u1_ovf); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset;
    test_digit1;
    test_digit4;
    test_backpressure;
    test_ignore_during_run;
    test_reset_mid_run;
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
